// File: rtl/ddr3_rx_lane_align.sv
// DDR3 RX lane read-capture alignment: trains bit-slip and delay taps against a fixed MPR word.
// Optional DDR3_RX_ALIGN_CENTER_EN: scan the whole passing tap window and finish at its centre.
module ddr3_rx_lane_align #(
    parameter logic [3:0]  TRAIN_PATTERN = 4'b0011,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned MATCH_CYCLES  = 16,
    parameter int unsigned MAX_TAPS      = 127
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic [3:0] RX_DATA_0,
    input  logic       TRAIN_START,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    output logic       RX_BIT_SLIP_0,
    output logic       DELAY_LINE_LOAD_0,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic [3:0] RX_DATA_OUT,
    output logic       RX_VALID,
    output logic       TRAIN_DONE,
    output logic       TRAIN_ERR
);
    localparam int unsigned TAP_W = $clog2(MAX_TAPS + 1);
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_SLIP    = 3'd4;
    localparam logic [2:0] S_MOVE    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_FAIL    = 3'd7;

    logic [2:0]       r_state, w_state_n;
    logic [CNT_W-1:0] r_settle_cnt, w_settle_n;
    logic [CNT_W-1:0] r_match_cnt, w_match_n;
    logic [1:0]       r_slip_cnt, w_slip_n;
    logic [TAP_W-1:0] r_tap_cnt, w_tap_n;
    logic             w_match, w_limit, w_dir_n;
    logic             r_slip, r_load, r_move, r_dir, r_valid, r_done, r_err;
    logic [3:0]       r_data;
`ifdef DDR3_RX_ALIGN_CENTER_EN
    logic             r_found, w_found_n, r_ret_mode, w_ret_mode_n, w_end_window;
    logic [TAP_W-1:0] r_win_lo, w_win_lo_n, r_ret_cnt, w_ret_n, w_center, w_ret_len;
`endif

    assign w_match = (RX_DATA_0 == TRAIN_PATTERN);
    assign w_limit = (r_tap_cnt == TAP_W'(MAX_TAPS)) || DELAY_LINE_OUT_OF_RANGE_0;
`ifdef DDR3_RX_ALIGN_CENTER_EN
    // Current tap is B (first failing / limit tap); window is [lo, B-1].
    assign w_center  = w_win_lo_n + ((r_tap_cnt - w_win_lo_n - TAP_W'(1)) >> 1);
    assign w_ret_len = r_tap_cnt - w_center;
`endif

    // Next-state and counter updates
    always_comb begin
        w_state_n  = r_state;
        w_settle_n = r_settle_cnt;
        w_match_n  = r_match_cnt;
        w_slip_n   = r_slip_cnt;
        w_tap_n    = r_tap_cnt;
`ifdef DDR3_RX_ALIGN_CENTER_EN
        w_found_n    = r_found;
        w_win_lo_n   = r_win_lo;
        w_ret_mode_n = r_ret_mode;
        w_ret_n      = r_ret_cnt;
        w_end_window = 1'b0;
`endif
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (TRAIN_START) begin
                    w_state_n = S_LOAD;
                    w_match_n = '0;
                    w_slip_n  = '0;
                    w_tap_n   = '0;
`ifdef DDR3_RX_ALIGN_CENTER_EN
                    w_found_n    = 1'b0;
                    w_ret_mode_n = 1'b0;
                    w_ret_n      = '0;
`endif
                end
            end
            S_LOAD: begin
                w_state_n  = S_SETTLE;
                w_settle_n = '0;
            end
            S_SETTLE: begin
                if (r_settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_state_n = S_COMPARE;
`ifdef DDR3_RX_ALIGN_CENTER_EN
                    if (r_ret_mode) w_state_n = (r_ret_cnt == '0) ? S_DONE : S_MOVE;
`endif
                end else begin
                    w_settle_n = r_settle_cnt + CNT_W'(1);
                end
            end
            S_COMPARE: begin
                if (w_match) begin
                    w_match_n = r_match_cnt + CNT_W'(1);
                    if (r_match_cnt == CNT_W'(MATCH_CYCLES - 1)) begin
`ifdef DDR3_RX_ALIGN_CENTER_EN
                        w_match_n = '0;
                        if (!r_found) begin
                            w_found_n  = 1'b1;
                            w_win_lo_n = r_tap_cnt;
                        end
                        if (w_limit) w_end_window = 1'b1;
                        else         w_state_n    = S_MOVE;
`else
                        w_state_n = S_DONE;
`endif
                    end
                end else begin
                    w_match_n = '0;
`ifdef DDR3_RX_ALIGN_CENTER_EN
                    if (r_found)                 w_end_window = 1'b1;
                    else
`endif
                    if (r_slip_cnt != 2'd3)      w_state_n = S_SLIP;
                    else if (w_limit)            w_state_n = S_FAIL;
                    else                         w_state_n = S_MOVE;
                end
            end
            S_SLIP: begin
                w_slip_n   = r_slip_cnt + 2'd1;
                w_state_n  = S_SETTLE;
                w_settle_n = '0;
            end
            S_MOVE: begin
                w_state_n  = S_SETTLE;
                w_settle_n = '0;
                w_slip_n   = '0;
                w_tap_n    = r_tap_cnt + TAP_W'(1);
`ifdef DDR3_RX_ALIGN_CENTER_EN
                if (r_ret_mode) begin
                    w_tap_n = r_tap_cnt - TAP_W'(1);
                    w_ret_n = r_ret_cnt - TAP_W'(1);
                end
`endif
            end
            default: w_state_n = S_IDLE;
        endcase
`ifdef DDR3_RX_ALIGN_CENTER_EN
        // Window closed: walk back down to its centre, or finish if it is a single tap at the limit.
        if (w_end_window) begin
            if (r_tap_cnt == w_win_lo_n) begin
                w_state_n = S_DONE;
            end else begin
                w_ret_mode_n = 1'b1;
                w_ret_n      = w_ret_len;
                w_state_n    = S_MOVE;
            end
        end
        w_dir_n = !((w_state_n == S_MOVE) && w_ret_mode_n);
`else
        w_dir_n = 1'b1;
`endif
    end

    // State, counters and registered outputs
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_match_cnt  <= '0;
            r_slip_cnt   <= '0;
            r_tap_cnt    <= '0;
            r_slip       <= 1'b0;
            r_load       <= 1'b0;
            r_move       <= 1'b0;
            r_dir        <= 1'b1;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_data       <= '0;
`ifdef DDR3_RX_ALIGN_CENTER_EN
            r_found      <= 1'b0;
            r_ret_mode   <= 1'b0;
            r_win_lo     <= '0;
            r_ret_cnt    <= '0;
`endif
        end else begin
            r_state      <= w_state_n;
            r_settle_cnt <= w_settle_n;
            r_match_cnt  <= w_match_n;
            r_slip_cnt   <= w_slip_n;
            r_tap_cnt    <= w_tap_n;
            r_slip       <= (w_state_n == S_SLIP);
            r_load       <= (w_state_n == S_LOAD);
            r_move       <= (w_state_n == S_MOVE);
            r_dir        <= w_dir_n;
            r_valid      <= (w_state_n == S_DONE);
            r_done       <= (w_state_n == S_DONE);
            r_err        <= (w_state_n == S_FAIL);
            r_data       <= (w_state_n == S_DONE) ? RX_DATA_0 : 4'd0;
`ifdef DDR3_RX_ALIGN_CENTER_EN
            r_found      <= w_found_n;
            r_ret_mode   <= w_ret_mode_n;
            r_win_lo     <= w_win_lo_n;
            r_ret_cnt    <= w_ret_n;
`endif
        end
    end

    assign RX_BIT_SLIP_0          = r_slip;
    assign DELAY_LINE_LOAD_0      = r_load;
    assign DELAY_LINE_MOVE_0      = r_move;
    assign DELAY_LINE_DIRECTION_0 = r_dir;
    assign RX_DATA_OUT            = r_data;
    assign RX_VALID               = r_valid;
    assign TRAIN_DONE             = r_done;
    assign TRAIN_ERR              = r_err;
endmodule

// File: tb/tb_ddr3_rx_lane_align.sv
// Bench for ddr3_rx_lane_align: a lane model reacts to slip/move/load pulses and results are
// compared against counts and latencies derived from the training rules.
module tb_ddr3_rx_lane_align;
    localparam logic [3:0] PAT    = 4'b0011;
    localparam int         SETTLE = 8;
    localparam int         MATCH  = 16;
    localparam int         TAPS   = 127;

    logic       FAB_CLK = 1'b0;
    logic       ARST_N;
    logic [3:0] RX_DATA_0;
    logic       TRAIN_START;
    logic       OOR;
    logic       SLIP, LOAD, MOVE, DIR, VALID, DONE, ERR;
    logic [3:0] DOUT;

    int errors = 0;
    int checks = 0;

    // Lane model state and per-run observations
    int m_tap, m_pos;
    int n_load, n_slip, n_up, n_dn, n_overlap, load_cyc, end_cyc;
    logic got_done, got_err;

    ddr3_rx_lane_align dut (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .RX_DATA_0(RX_DATA_0), .TRAIN_START(TRAIN_START),
        .DELAY_LINE_OUT_OF_RANGE_0(OOR), .RX_BIT_SLIP_0(SLIP), .DELAY_LINE_LOAD_0(LOAD),
        .DELAY_LINE_MOVE_0(MOVE), .DELAY_LINE_DIRECTION_0(DIR), .RX_DATA_OUT(DOUT),
        .RX_VALID(VALID), .TRAIN_DONE(DONE), .TRAIN_ERR(ERR)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    // The lane shows the pattern only inside the tap window and at the right bit rotation.
    function automatic logic [3:0] lane_word(int tap, int pos, int lo, int hi, int need, logic [3:0] bad);
        return (tap >= lo && tap <= hi && pos == need) ? PAT : bad;
    endfunction

    // Slips needed at the first good tap p: each failing tap rotates the lane by 3 positions.
    function automatic int slips_at(int p, int need);
        return (need + 4 - ((3 * p) % 4)) % 4;
    endfunction

    function automatic int train_cycles(int p, int k);
        return 1 + SETTLE + MATCH + (SETTLE + 2) * (4 * p + k);
    endfunction

    function automatic logic [3:0] rand_bad();
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        while (w == PAT) w = 4'($urandom_range(0, 15));
        return w;
    endfunction

    task automatic run_train(input int lo, input int hi, input int need, input int oor_tap,
                             input logic [3:0] bad, input int budget, input int restart_at);
        m_tap = 0; m_pos = 0;
        n_load = 0; n_slip = 0; n_up = 0; n_dn = 0; n_overlap = 0;
        load_cyc = -1; end_cyc = -1; got_done = 1'b0; got_err = 1'b0;
        RX_DATA_0 = lane_word(m_tap, m_pos, lo, hi, need, bad);
        OOR = (m_tap >= oor_tap);
        TRAIN_START = 1'b1;
        @(posedge FAB_CLK); #1;
        TRAIN_START = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (int'(LOAD) + int'(SLIP) + int'(MOVE) > 1) n_overlap++;
            if (LOAD) begin n_load++; load_cyc = cyc; m_tap = 0; end
            if (SLIP) begin n_slip++; m_pos = (m_pos + 1) % 4; end
            if (MOVE) begin
                if (DIR) begin n_up++; m_tap++; end
                else     begin n_dn++; m_tap--; end
            end
            if (DONE || ERR) begin
                end_cyc = cyc; got_done = DONE; got_err = ERR;
                break;
            end
            TRAIN_START = (cyc == restart_at);
            RX_DATA_0 = lane_word(m_tap, m_pos, lo, hi, need, bad);
            OOR = (m_tap >= oor_tap);
            @(posedge FAB_CLK); #1;
        end
        TRAIN_START = 1'b0;
        checks++;
        if (!got_done && !got_err) begin
            errors++;
            $display("FAIL train_timeout: no DONE/ERR within %0d cycles", budget);
        end
        checks++;
        if (n_overlap !== 0) begin
            errors++;
            $display("FAIL pulse_overlap: got %0d cycles with >1 pulse, expected 0", n_overlap);
        end
    endtask

    task automatic test_reset();
        logic seen;
        ARST_N = 1'b0; TRAIN_START = 1'b0; RX_DATA_0 = 4'd0; OOR = 1'b0;
        repeat (3) @(posedge FAB_CLK); #1;
        checks++;
        if ({LOAD, SLIP, MOVE, VALID, DONE, ERR, DOUT, DIR} !== 11'b1) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", {LOAD, SLIP, MOVE, VALID, DONE, ERR, DOUT, DIR}, 11'b1);
        end
        ARST_N = 1'b1;
        @(posedge FAB_CLK); #1;
        RX_DATA_0 = PAT; TRAIN_START = 1'b1;
        @(posedge FAB_CLK); #1;
        TRAIN_START = 1'b0;
        checks++;
        if (LOAD !== 1'b1) begin
            errors++;
            $display("FAIL reset_prep_load: got %b expected 1", LOAD);
        end
        repeat (4) @(posedge FAB_CLK);
        #3 ARST_N = 1'b0;
        #1;
        checks++;
        if ({LOAD, SLIP, MOVE, VALID, DONE, ERR, DOUT, DIR} !== 11'b1) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", {LOAD, SLIP, MOVE, VALID, DONE, ERR, DOUT, DIR}, 11'b1);
        end
        repeat (3) @(posedge FAB_CLK); #1;
        ARST_N = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge FAB_CLK); #1;
            if (DONE || LOAD || VALID) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: got activity=%b expected 0", seen);
        end
    endtask

    task automatic test_aligned();
        // Extra TRAIN_START mid-training must be ignored.
        run_train(0, 1000, 0, 1000, rand_bad(), 200, 5);
        checks++;
        if (got_done !== 1'b1 || n_load !== 1 || n_slip !== 0 || n_up !== 0) begin
            errors++;
            $display("FAIL aligned_counts: got done=%b load=%0d slip=%0d move=%0d expected 1 1 0 0",
                     got_done, n_load, n_slip, n_up);
        end
        checks++;
        if (end_cyc - load_cyc !== 1 + SETTLE + MATCH) begin
            errors++;
            $display("FAIL aligned_latency: got %0d expected %0d", end_cyc - load_cyc, 1 + SETTLE + MATCH);
        end
        checks++;
        if (VALID !== 1'b1 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL aligned_flags: got valid=%b err=%b expected 1 0", VALID, ERR);
        end
        @(posedge FAB_CLK); #1;
        checks++;
        if (DOUT !== PAT) begin
            errors++;
            $display("FAIL aligned_data: got %b expected %b", DOUT, PAT);
        end
    endtask

    task automatic test_passthrough();
        logic [3:0] prev;
        prev = 4'($urandom_range(0, 15));
        RX_DATA_0 = prev;
        @(posedge FAB_CLK); #1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (DOUT !== prev || VALID !== 1'b1) begin
                errors++;
                $display("FAIL passthrough_%0d: got %b/%b expected %b/1", i, DOUT, VALID, prev);
            end
            prev = 4'($urandom_range(0, 15));
            RX_DATA_0 = prev;
            @(posedge FAB_CLK); #1;
        end
    endtask

    task automatic test_search(input string name, input int p, input int need, input logic [3:0] bad);
        int k;
        k = slips_at(p, need);
        run_train(p, 1000, need, 1000, bad, 3000, -1);
        checks++;
        if (got_done !== 1'b1 || n_up !== p || n_dn !== 0 || n_slip !== 3 * p + k || m_tap !== p) begin
            errors++;
            $display("FAIL %s_counts: got done=%b up=%0d dn=%0d slip=%0d tap=%0d expected 1 %0d 0 %0d %0d",
                     name, got_done, n_up, n_dn, n_slip, m_tap, p, 3 * p + k, p);
        end
        checks++;
        if (end_cyc - load_cyc !== train_cycles(p, k)) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, end_cyc - load_cyc, train_cycles(p, k));
        end
    endtask

    task automatic test_fail(input string name, input int oor_tap, input int exp_moves);
        run_train(1000, 0, 0, oor_tap, 4'b1111, 8000, -1);
        checks++;
        if (got_err !== 1'b1 || got_done !== 1'b0 || n_up !== exp_moves) begin
            errors++;
            $display("FAIL %s: got err=%b done=%b moves=%0d expected 1 0 %0d", name, got_err, got_done, n_up, exp_moves);
        end
        repeat (3) @(posedge FAB_CLK); #1;
        checks++;
        if (ERR !== 1'b1 || VALID !== 1'b0 || DOUT !== 4'd0 || MOVE !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: got err=%b valid=%b dout=%b move=%b expected 1 0 0000 0", name, ERR, VALID, DOUT, MOVE);
        end
    endtask

`ifdef DDR3_RX_ALIGN_CENTER_EN
    task automatic test_center();
        run_train(4, 12, 0, 1000, 4'b1111, 3000, -1);
        checks++;
        if (got_done !== 1'b1 || n_up !== 13 || n_dn !== 5 || m_tap !== 8) begin
            errors++;
            $display("FAIL center: got done=%b up=%0d dn=%0d tap=%0d expected 1 13 5 8", got_done, n_up, n_dn, m_tap);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef DDR3_RX_ALIGN_CENTER_EN
        test_center();
`else
        test_aligned();
        test_passthrough();
        test_search("slip2", 0, 2, 4'b1100);
        test_search("tap5", 5, 0, rand_bad());
        for (int i = 0; i < 4; i++)
            test_search($sformatf("rand%0d", i), $urandom_range(0, 12), $urandom_range(0, 3), rand_bad());
        test_fail("fail_max_taps", 1000, TAPS);
        test_fail("fail_oor", 10, 10);
        test_aligned();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
